// File: rtl/ysyx_20020207_bus_pkg.sv
// Shared AXI-lite response codes and arbiter channel FSM state encodings.
package ysyx_20020207_bus_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2,
        R_ERR  = 2'd3
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2,
        W_ERR  = 2'd3
    } wr_state_t;

    // Watchdog counter width; a disabled watchdog still needs a 1-bit register.
    function automatic int wd_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/ysyx_20020207_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N.
// Zero latency; purely a function of req and ptr.
module ysyx_20020207_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        logic [IW-1:0] w_idx;
        w_idx     = '0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        // Scan from the farthest offset down so the closest one to ptr wins.
        for (int off = N - 1; off >= 0; off--) begin
            w_idx = IW'((int'(ptr) + off) % N);
            if (req[w_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/ysyx_20020207_rr_axi_arbiter.sv
// N:1 AXI-lite arbiter with independent round-robin read/write channels and per-channel watchdogs.
// Grant is same-cycle in IDLE, downstream valid rises next cycle; grant held until the response completes.
module ysyx_20020207_rr_axi_arbiter
    import ysyx_20020207_bus_pkg::*;
#(
    parameter int N       = 2,
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N-1:0]        m_arvalid,
    output logic [N-1:0]        m_arready,
    input  logic [N*AW-1:0]     m_araddr,
    output logic [N-1:0]        m_rvalid,
    input  logic [N-1:0]        m_rready,
    output logic [1:0]          m_rresp,
    output logic [DW-1:0]       m_rdata,
    input  logic [N-1:0]        m_awvalid,
    output logic [N-1:0]        m_awready,
    input  logic [N*AW-1:0]     m_awaddr,
    input  logic [N-1:0]        m_wvalid,
    output logic [N-1:0]        m_wready,
    input  logic [N*DW-1:0]     m_wdata,
    input  logic [N*DW/8-1:0]   m_wstrb,
    output logic [N-1:0]        m_bvalid,
    input  logic [N-1:0]        m_bready,
    output logic [1:0]          m_bresp,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [AW-1:0]       s_araddr,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [1:0]          s_rresp,
    input  logic [DW-1:0]       s_rdata,
    output logic                s_awvalid,
    input  logic                s_awready,
    output logic [AW-1:0]       s_awaddr,
    output logic                s_wvalid,
    input  logic                s_wready,
    output logic [DW-1:0]       s_wdata,
    output logic [DW/8-1:0]     s_wstrb,
    input  logic                s_bvalid,
    output logic                s_bready,
    input  logic [1:0]          s_bresp
);

    localparam int            IW     = (N > 1) ? $clog2(N) : 1;
    localparam int            SW     = DW / 8;
    localparam int            CW     = wd_width(TIMEOUT);
    localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT);

    // ---------------- read channel ----------------
    rd_state_t     r_rstate, w_rnext;
    logic [IW-1:0] r_rptr, r_rgnt, w_rpick_idx;
    logic          w_rpick_vld;
    logic [AW-1:0] r_raddr;
    logic [CW-1:0] r_rcnt;
    logic          w_rto;

    ysyx_20020207_rr_pick #(.N(N), .IW(IW)) u_rd_pick (
        .req       (m_arvalid),
        .ptr       (r_rptr),
        .gnt_valid (w_rpick_vld),
        .gnt_idx   (w_rpick_idx)
    );

    assign w_rto    = (TIMEOUT != 0) && (r_rcnt == WD_MAX);
    assign s_araddr = r_raddr;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rstate <= R_IDLE;
            r_rptr   <= '0;
            r_rgnt   <= '0;
            r_raddr  <= '0;
            r_rcnt   <= '0;
        end else begin
            r_rstate <= w_rnext;
            if (r_rstate == R_IDLE && w_rpick_vld) begin
                r_rgnt  <= w_rpick_idx;
                r_raddr <= m_araddr[w_rpick_idx*AW +: AW];
                r_rptr  <= (w_rpick_idx == IW'(N - 1)) ? '0 : w_rpick_idx + IW'(1);
            end
            // Saturating wait counter, restarted on every state change.
            if (w_rnext != r_rstate)
                r_rcnt <= '0;
            else if (r_rcnt != WD_MAX)
                r_rcnt <= r_rcnt + CW'(1);
        end
    end

    always_comb begin
        w_rnext   = r_rstate;
        m_arready = '0;
        m_rvalid  = '0;
        m_rresp   = RESP_OKAY;
        m_rdata   = '0;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                // Sink stray beats left behind by an abandoned transaction.
                s_rready = 1'b1;
                if (w_rpick_vld && !reset) begin
                    m_arready[w_rpick_idx] = 1'b1;
                    w_rnext                = R_ADDR;
                end
            end
            R_ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready)  w_rnext = R_DATA;
                else if (w_rto) w_rnext = R_ERR;
            end
            R_DATA: begin
                m_rvalid[r_rgnt] = s_rvalid;
                m_rdata          = s_rdata;
                m_rresp          = s_rresp;
                s_rready         = m_rready[r_rgnt];
                if (s_rvalid && m_rready[r_rgnt]) w_rnext = R_IDLE;
                else if (w_rto)                   w_rnext = R_ERR;
            end
            R_ERR: begin
                m_rvalid[r_rgnt] = 1'b1;
                m_rresp          = RESP_SLVERR;
                if (m_rready[r_rgnt]) w_rnext = R_IDLE;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    // ---------------- write channel ----------------
    wr_state_t     r_wstate, w_wnext;
    logic [IW-1:0] r_wptr, r_wgnt, w_wpick_idx;
    logic          w_wpick_vld;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic [SW-1:0] r_wstrb;
    logic          r_aw_done, r_w_done;
    logic [CW-1:0] r_wcnt;
    logic          w_wto, w_aw_hs, w_w_hs, w_wphase;

    ysyx_20020207_rr_pick #(.N(N), .IW(IW)) u_wr_pick (
        .req       (m_awvalid & m_wvalid),
        .ptr       (r_wptr),
        .gnt_valid (w_wpick_vld),
        .gnt_idx   (w_wpick_idx)
    );

    assign w_wto    = (TIMEOUT != 0) && (r_wcnt == WD_MAX);
    assign s_awaddr = r_waddr;
    assign s_wdata  = r_wdata;
    assign s_wstrb  = r_wstrb;
    assign w_aw_hs  = s_awvalid && s_awready;
    assign w_w_hs   = s_wvalid && s_wready;
    assign w_wphase = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_wptr    <= '0;
            r_wgnt    <= '0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wcnt    <= '0;
        end else begin
            r_wstate <= w_wnext;
            if (r_wstate == W_IDLE && w_wpick_vld) begin
                r_wgnt    <= w_wpick_idx;
                r_waddr   <= m_awaddr[w_wpick_idx*AW +: AW];
                r_wdata   <= m_wdata[w_wpick_idx*DW +: DW];
                r_wstrb   <= m_wstrb[w_wpick_idx*SW +: SW];
                r_wptr    <= (w_wpick_idx == IW'(N - 1)) ? '0 : w_wpick_idx + IW'(1);
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
            if (w_aw_hs) r_aw_done <= 1'b1;
            if (w_w_hs)  r_w_done  <= 1'b1;
            if (w_wnext != r_wstate)
                r_wcnt <= '0;
            else if (r_wcnt != WD_MAX)
                r_wcnt <= r_wcnt + CW'(1);
        end
    end

    always_comb begin
        w_wnext   = r_wstate;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = RESP_OKAY;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_bready  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_bready = 1'b1;
                if (w_wpick_vld && !reset) begin
                    m_awready[w_wpick_idx] = 1'b1;
                    m_wready[w_wpick_idx]  = 1'b1;
                    w_wnext                = W_REQ;
                end
            end
            W_REQ: begin
                // AW and W retire independently; the phase ends once both have.
                s_awvalid = !r_aw_done;
                s_wvalid  = !r_w_done;
                if (w_wphase)   w_wnext = W_RESP;
                else if (w_wto) w_wnext = W_ERR;
            end
            W_RESP: begin
                m_bvalid[r_wgnt] = s_bvalid;
                m_bresp          = s_bresp;
                s_bready         = m_bready[r_wgnt];
                if (s_bvalid && m_bready[r_wgnt]) w_wnext = W_IDLE;
                else if (w_wto)                   w_wnext = W_ERR;
            end
            W_ERR: begin
                m_bvalid[r_wgnt] = 1'b1;
                m_bresp          = RESP_SLVERR;
                if (m_bready[r_wgnt]) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_20020207_rr_axi_arbiter.sv
// Scoreboard bench for the round-robin AXI-lite arbiter (N=2, watchdog limit 4).
module tb_ysyx_20020207_rr_axi_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      m_arvalid, m_arready, m_rvalid, m_rready;
    logic [N*AW-1:0]   m_araddr, m_awaddr;
    logic [1:0]        m_rresp, m_bresp;
    logic [DW-1:0]     m_rdata;
    logic [N-1:0]      m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic              s_arvalid, s_arready, s_rvalid, s_rready;
    logic [AW-1:0]     s_araddr, s_awaddr;
    logic [1:0]        s_rresp, s_bresp;
    logic [DW-1:0]     s_rdata, s_wdata;
    logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [SW-1:0]     s_wstrb;

    int n_checks = 0;
    int n_err    = 0;
    int m_rptr   = 0;
    int m_wptr   = 0;
    logic [AW-1:0] addr_tab [N] = '{32'h8000_0000, 32'h8000_0100};

    ysyx_20020207_rr_axi_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rresp(m_rresp), .m_rdata(m_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp), .s_rdata(s_rdata),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
    );

    always #5 clock = ~clock;

    // Reference round-robin choice: first requester at or after ptr.
    function automatic int rr_model(input logic [N-1:0] req, input int ptr);
        int g;
        g = -1;
        for (int off = 0; off < N; off++) begin
            if (g < 0 && req[(ptr + off) % N]) g = (ptr + off) % N;
        end
        return g;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        m_arvalid = '0; m_rready = '0; m_araddr = '0;
        m_awvalid = '0; m_wvalid = '0; m_bready = '0;
        m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rresp = '0; s_rdata = '0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = '0;
        repeat (3) @(negedge clock);
        m_arvalid = 2'b11;
        #1;
        n_checks++;
        if (m_arready !== 2'b00) begin
            n_err++; $display("FAIL reset_arready_held: got %b want 00", m_arready);
        end
        @(negedge clock);
        reset = 1'b0; m_arvalid = '0; m_rptr = 0; m_wptr = 0;
        #1;
        n_checks++;
        if ({m_arready, m_awready, m_wready} !== '0) begin
            n_err++; $display("FAIL reset_readies: got %b want 0", {m_arready, m_awready, m_wready});
        end
        n_checks++;
        if ({m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid} !== '0) begin
            n_err++; $display("FAIL reset_valids: got %b want 0", {m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid});
        end
        n_checks++;
        if ({m_rdata, m_rresp, m_bresp} !== '0) begin
            n_err++; $display("FAIL reset_resp_data: got rdata=%h rresp=%b bresp=%b want 0", m_rdata, m_rresp, m_bresp);
        end
        n_checks++;
        if ({s_rready, s_bready} !== 2'b11) begin
            n_err++; $display("FAIL reset_sink_ready: got %b want 11", {s_rready, s_bready});
        end
    endtask

    // keep=0: each requester drops its valid once granted; keep=1: both request continuously.
    task automatic test_read_rr(input bit keep, input int nreads);
        logic [AW-1:0] q_addr[$];
        logic [DW-1:0] q_data[$];
        int            q_own[$];
        int            done_cnt, g, drop, own;
        bit            hs_ar, hs_r;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        done_cnt = 0;
        @(negedge clock);
        m_araddr = {addr_tab[1], addr_tab[0]};
        m_arvalid = 2'b11; m_rready = 2'b11; s_arready = 1'b1; s_rvalid = 1'b0; s_rresp = 2'b00;
        for (int cyc = 0; cyc < 200 && done_cnt < nreads; cyc++) begin
            #1;
            hs_ar = 1'b0; drop = -1;
            if (|m_arready) begin
                g = rr_model(m_arvalid, m_rptr);
                n_checks++;
                if (g < 0 || m_arready !== onehot(g)) begin
                    n_err++; $display("FAIL rd_grant: got %b want %b", m_arready, onehot(g));
                end
                if (g >= 0) begin
                    m_rptr = (g + 1) % N;
                    q_addr.push_back(addr_tab[g]);
                    q_own.push_back(g);
                    if (!keep) drop = g;
                end
            end
            if (s_arvalid && s_arready) begin
                hs_ar = 1'b1;
                ea = (q_addr.size() > 0) ? q_addr.pop_front() : '1;
                n_checks++;
                if (s_araddr !== ea) begin
                    n_err++; $display("FAIL rd_araddr: got %h want %h", s_araddr, ea);
                end
            end
            if (|m_rvalid) begin
                own = (q_own.size() > 0) ? q_own.pop_front() : -1;
                ed  = (q_data.size() > 0) ? q_data.pop_front() : '1;
                n_checks++;
                if (m_rvalid !== onehot(own) || m_rdata !== ed || m_rresp !== 2'b00) begin
                    n_err++; $display("FAIL rd_beat: got v=%b d=%h r=%b want v=%b d=%h r=00", m_rvalid, m_rdata, m_rresp, onehot(own), ed);
                end
                done_cnt++;
            end
            hs_r = s_rvalid && s_rready;
            @(negedge clock);
            if (drop >= 0) m_arvalid[drop] = 1'b0;
            if (hs_r) s_rvalid = 1'b0;
            if (hs_ar) begin
                s_rvalid = 1'b1;
                s_rdata  = {$urandom, $urandom};
                q_data.push_back(s_rdata);
            end
        end
        m_arvalid = '0;
        n_checks++;
        if (done_cnt != nreads) begin
            n_err++; $display("FAIL rd_stream_done: got %0d beats want %0d", done_cnt, nreads);
        end
    endtask

    task automatic test_concurrent();
        logic [AW-1:0] q_wa[$];
        logic [DW-1:0] q_wd[$];
        logic [SW-1:0] q_ws[$];
        int gr, gw;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [SW-1:0] es;
        @(negedge clock);
        m_araddr  = {32'h0, 32'h8000_0040}; m_arvalid = 2'b01;
        m_awaddr  = {32'h8000_1000, 32'h0};
        m_wdata   = {64'hDEAD_BEEF, 64'h0};
        m_wstrb   = {8'h0F, 8'h00};
        m_awvalid = 2'b10; m_wvalid = 2'b10;
        q_wa.push_back(32'h8000_1000); q_wd.push_back(64'hDEAD_BEEF); q_ws.push_back(8'h0F);
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1; m_rready = 2'b11; m_bready = 2'b11;
        #1;
        gr = rr_model(m_arvalid, m_rptr); m_rptr = (gr + 1) % N;
        gw = rr_model(m_awvalid & m_wvalid, m_wptr); m_wptr = (gw + 1) % N;
        n_checks++;
        if (m_arready !== onehot(gr) || m_awready !== onehot(gw) || m_wready !== onehot(gw)) begin
            n_err++; $display("FAIL cc_grants: got ar=%b aw=%b w=%b want ar=%b aw/w=%b", m_arready, m_awready, m_wready, onehot(gr), onehot(gw));
        end
        @(negedge clock);
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
        #1;
        n_checks++;
        if ({s_arvalid, s_awvalid, s_wvalid} !== 3'b111) begin
            n_err++; $display("FAIL cc_issue_same_cycle: got %b want 111", {s_arvalid, s_awvalid, s_wvalid});
        end
        ea = q_wa.pop_front(); ed = q_wd.pop_front(); es = q_ws.pop_front();
        n_checks++;
        if (s_awaddr !== ea || s_wdata !== ed || s_wstrb !== es || s_araddr !== 32'h8000_0040) begin
            n_err++; $display("FAIL cc_payload: got aw=%h wd=%h ws=%h ar=%h want %h %h %h 80000040", s_awaddr, s_wdata, s_wstrb, s_araddr, ea, ed, es);
        end
        @(negedge clock);
        s_rvalid = 1'b1; s_rdata = 64'h0000_1111_2222_3333; s_rresp = 2'b00;
        #1;
        n_checks++;
        if (m_rvalid !== onehot(gr) || m_bvalid !== 2'b00 || m_rdata !== 64'h0000_1111_2222_3333) begin
            n_err++; $display("FAIL cc_read_first: got rv=%b bv=%b d=%h want rv=%b bv=00", m_rvalid, m_bvalid, m_rdata, onehot(gr));
        end
        @(negedge clock);
        s_rvalid = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b00;
        #1;
        n_checks++;
        if (m_bvalid !== onehot(gw) || m_bresp !== 2'b00 || m_rvalid !== 2'b00) begin
            n_err++; $display("FAIL cc_write_resp: got bv=%b br=%b rv=%b want bv=%b br=00 rv=00", m_bvalid, m_bresp, m_rvalid, onehot(gw));
        end
        @(negedge clock);
        s_bvalid = 1'b0;
    endtask

    task automatic test_read_timeout();
        int g, first;
        logic [N-1:0] v_at;
        logic [1:0]   r_at;
        logic [DW-1:0] d_at;
        logic          ar_at;
        first = -1; v_at = '0; r_at = '0; d_at = '0; ar_at = 1'b0;
        @(negedge clock);
        s_arready = 1'b0; m_rready = 2'b00; m_arvalid = 2'b10;
        #1;
        g = rr_model(m_arvalid, m_rptr); m_rptr = (g + 1) % N;
        n_checks++;
        if (m_arready !== onehot(g)) begin
            n_err++; $display("FAIL to_grant: got %b want %b", m_arready, onehot(g));
        end
        for (int k = 1; k <= 12 && first < 0; k++) begin
            @(negedge clock);
            m_arvalid = '0;
            #1;
            if (|m_rvalid) begin
                first = k; v_at = m_rvalid; r_at = m_rresp; d_at = m_rdata; ar_at = s_arvalid;
            end
        end
        n_checks++;
        if (first != 6) begin
            n_err++; $display("FAIL to_latency: got %0d cycles want 6", first);
        end
        n_checks++;
        if (v_at !== onehot(g) || r_at !== 2'b10 || d_at !== '0 || ar_at !== 1'b0) begin
            n_err++; $display("FAIL to_err_beat: got v=%b r=%b d=%h ar=%b want v=%b r=10 d=0 ar=0", v_at, r_at, d_at, ar_at, onehot(g));
        end
        @(negedge clock);
        #1;
        n_checks++;
        if (m_rvalid !== onehot(g) || m_rresp !== 2'b10) begin
            n_err++; $display("FAIL to_err_hold: got v=%b r=%b want v=%b r=10", m_rvalid, m_rresp, onehot(g));
        end
        @(negedge clock);
        m_rready = 2'b11;
        @(negedge clock);
        s_rvalid = 1'b1; s_rdata = 64'hBAD0_BAD0_BAD0_BAD0; s_arready = 1'b1;
        #1;
        n_checks++;
        if (m_rvalid !== 2'b00 || s_rready !== 1'b1) begin
            n_err++; $display("FAIL to_late_beat_sunk: got rv=%b s_rready=%b want 00 1", m_rvalid, s_rready);
        end
        @(negedge clock);
        s_rvalid = 1'b0;
    endtask

    task automatic test_write_split();
        int   g, nw, naw, nb;
        bit   aw_hs, b_hs;
        bit   drop_first_seen;
        nw = 0; naw = 0; nb = 0; aw_hs = 1'b0; b_hs = 1'b0; drop_first_seen = 1'b0;
        @(negedge clock);
        m_awaddr = {32'h0, 32'h8000_2000}; m_wdata = {64'h0, 64'h0123_4567_89AB_CDEF};
        m_wstrb = {8'h00, 8'hFF}; m_awvalid = 2'b01; m_wvalid = 2'b01;
        s_awready = 1'b0; s_wready = 1'b1; m_bready = 2'b11;
        #1;
        g = rr_model(m_awvalid & m_wvalid, m_wptr); m_wptr = (g + 1) % N;
        n_checks++;
        if (m_awready !== onehot(g) || m_wready !== onehot(g)) begin
            n_err++; $display("FAIL ws_grant: got aw=%b w=%b want %b", m_awready, m_wready, onehot(g));
        end
        for (int k = 1; k <= 14; k++) begin
            @(negedge clock);
            m_awvalid = '0; m_wvalid = '0;
            s_awready = (k >= 4);
            if (b_hs) s_bvalid = 1'b0;
            if (aw_hs) begin s_bvalid = 1'b1; s_bresp = 2'b00; end
            #1;
            aw_hs = s_awvalid && s_awready;
            if (aw_hs) naw++;
            if (s_wvalid && s_wready) nw++;
            if (k == 2) drop_first_seen = (s_wvalid === 1'b0) && (s_awvalid === 1'b1);
            if (|m_bvalid) begin
                nb++;
                n_checks++;
                if (m_bvalid !== onehot(g) || m_bresp !== 2'b00) begin
                    n_err++; $display("FAIL ws_bbeat: got bv=%b br=%b want bv=%b br=00", m_bvalid, m_bresp, onehot(g));
                end
            end
            b_hs = s_bvalid && s_bready;
        end
        n_checks++;
        if (!drop_first_seen) begin
            n_err++; $display("FAIL ws_wvalid_drops_first: got w-before-aw=0 want 1");
        end
        n_checks++;
        if (nb != 1 || nw != 1 || naw != 1) begin
            n_err++; $display("FAIL ws_counts: got b=%0d w=%0d aw=%0d want 1 1 1", nb, nw, naw);
        end
    endtask

    task automatic test_mid_reset();
        int g;
        @(negedge clock);
        m_arvalid = 2'b01; m_rready = 2'b11; s_arready = 1'b1; s_rvalid = 1'b0;
        #1;
        g = rr_model(m_arvalid, m_rptr); m_rptr = (g + 1) % N;
        @(negedge clock);
        m_arvalid = '0;
        @(negedge clock);
        #1;
        n_checks++;
        if (s_rready !== 1'b1 || m_rvalid !== 2'b00 || s_arvalid !== 1'b0) begin
            n_err++; $display("FAIL mr_in_rdata: got srr=%b rv=%b sar=%b want 1 00 0", s_rready, m_rvalid, s_arvalid);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; m_rptr = 0; m_wptr = 0;
        #1;
        n_checks++;
        if ({m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid} !== '0 || {s_rready, s_bready} !== 2'b11) begin
            n_err++; $display("FAIL mr_idle: got valids=%b sink=%b want 0 11", {m_rvalid, m_bvalid, s_arvalid, s_awvalid, s_wvalid}, {s_rready, s_bready});
        end
        m_arvalid = 2'b11;
        #1;
        g = rr_model(m_arvalid, m_rptr);
        n_checks++;
        if (m_arready !== onehot(g)) begin
            n_err++; $display("FAIL mr_ptr_reset: got %b want %b", m_arready, onehot(g));
        end
        @(negedge clock);
        m_arvalid = '0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_read_rr(1'b0, 2);
        test_read_rr(1'b1, 8);
        test_concurrent();
        test_read_timeout();
        test_write_split();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
